// File: rtl/alu_issue_stage_if.sv
// Decode-side request channel and writeback-side result channel of the ALU issue stage.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface alu_issue_stage_if #(
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       op_i;
    logic [63:0]      a_i;
    logic [63:0]      b_i;
    logic [TAG_W-1:0] tag_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [63:0]      result_o;
    logic [TAG_W-1:0] tag_o;
    logic             c_o;
    logic             v_o;
    logic             z_o;
    logic             err_o;

    // The stage itself.
    modport slave (
        input  in_valid_i, op_i, a_i, b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o, c_o, v_o, z_o, err_o
    );

    // Decode/writeback environment around the stage.
    modport master (
        output in_valid_i, op_i, a_i, b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o, c_o, v_o, z_o, err_o
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-register execute stage around an external 64-bit add/AND ALU: S1 drives the ALU
// operands and controls, S2 captures result, flags and tag for writeback.
module alu_issue_stage #(
    parameter int TAG_W = 5
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    alu_issue_stage_if.slave   bus,
    output logic [63:0]        alu_a_o,
    output logic [63:0]        alu_b_o,
    output logic               alu_c_o,
    output logic               alu_sum_en_o,
    output logic               alu_and_en_o,
    input  logic [63:0]        alu_out_i,
    input  logic               alu_c_i,
    input  logic               alu_v_i,
    input  logic               alu_z_i
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_SLT  = 3'b011,
        OP_SLTU = 3'b100
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [63:0]      s1_a_q, s1_a_d;
    logic [63:0]      s1_b_q, s1_b_d;
    logic             s1_c_q, s1_c_d;
    logic             s1_sum_en_q, s1_sum_en_d;
    logic             s1_and_en_q, s1_and_en_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [63:0]      s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_c_q, s2_c_d;
    logic             s2_v_q, s2_v_d;
    logic             s2_z_q, s2_z_d;
    logic             s2_err_q, s2_err_d;

    logic s2_free;
    logic in_ready;
    logic accept;
    logic advance;

    // Ready depends only on stage occupancy and out_ready_i, never on in_valid_i.
    assign s2_free  = ~s2_valid_q | bus.out_ready_i;
    assign in_ready = ~s1_valid_q | s2_free;
    assign accept   = bus.in_valid_i & in_ready;
    assign advance  = s1_valid_q & s2_free;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_c_d      = s1_c_q;
        s1_sum_en_d = s1_sum_en_q;
        s1_and_en_d = s1_and_en_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;

        if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = bus.a_i;
            s1_b_d      = bus.b_i;
            s1_c_d      = 1'b0;
            s1_sum_en_d = 1'b0;
            s1_and_en_d = 1'b0;
            s1_op_d     = bus.op_i;
            s1_tag_d    = bus.tag_i;
            case (op_e'(bus.op_i))
                OP_ADD: s1_sum_en_d = 1'b1;
                OP_SUB, OP_SLT, OP_SLTU: begin
                    s1_b_d      = ~bus.b_i;
                    s1_c_d      = 1'b1;
                    s1_sum_en_d = 1'b1;
                end
                OP_AND: s1_and_en_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_c_d      = s2_c_q;
        s2_v_d      = s2_v_q;
        s2_z_d      = s2_z_q;
        s2_err_d    = s2_err_q;

        if (bus.out_ready_i) begin
            s2_valid_d = 1'b0;
        end
        if (advance) begin
            s2_valid_d = 1'b1;
            s2_tag_d   = s1_tag_q;
            s2_c_d     = alu_c_i;
            s2_v_d     = alu_v_i;
            s2_z_d     = alu_z_i;
            s2_err_d   = 1'b0;
            // Compares reuse the subtraction: signed via sign^overflow, unsigned via borrow.
            case (op_e'(s1_op_q))
                OP_ADD, OP_SUB, OP_AND: s2_result_d = alu_out_i;
                OP_SLT:  s2_result_d = {63'b0, alu_out_i[63] ^ alu_v_i};
                OP_SLTU: s2_result_d = {63'b0, ~alu_c_i};
                default: begin
                    s2_result_d = 64'b0;
                    s2_err_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= 64'b0;
            s1_b_q      <= 64'b0;
            s1_c_q      <= 1'b0;
            s1_sum_en_q <= 1'b0;
            s1_and_en_q <= 1'b0;
            s1_op_q     <= 3'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 64'b0;
            s2_tag_q    <= '0;
            s2_c_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_z_q      <= 1'b0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_sum_en_q <= s1_sum_en_d;
            s1_and_en_q <= s1_and_en_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_c_q      <= s2_c_d;
            s2_v_q      <= s2_v_d;
            s2_z_q      <= s2_z_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.result_o    = s2_result_q;
    assign bus.tag_o       = s2_tag_q;
    assign bus.c_o         = s2_c_q;
    assign bus.v_o         = s2_v_q;
    assign bus.z_o         = s2_z_q;
    assign bus.err_o       = s2_err_q;

    assign alu_a_o      = s1_a_q;
    assign alu_b_o      = s1_b_q;
    assign alu_c_o      = s1_c_q;
    assign alu_sum_en_o = s1_sum_en_q;
    assign alu_and_en_o = s1_and_en_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random checks of alu_issue_stage against a behavioural ALU and an
// opcode-level reference model feeding an expected-result queue.
module tb_alu_issue_stage;
    localparam int TAG_W = 5;
    localparam int W     = 64 + TAG_W + 4;

    logic clk_i;
    logic reset_ni;

    logic [63:0] alu_a_o, alu_b_o, alu_out_i;
    logic        alu_c_o, alu_sum_en_o, alu_and_en_o;
    logic        alu_c_i, alu_v_i, alu_z_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    alu_issue_stage_if #(.TAG_W(TAG_W)) bus();

    alu_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .bus          (bus),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_c_o      (alu_c_o),
        .alu_sum_en_o (alu_sum_en_o),
        .alu_and_en_o (alu_and_en_o),
        .alu_out_i    (alu_out_i),
        .alu_c_i      (alu_c_i),
        .alu_v_i      (alu_v_i),
        .alu_z_i      (alu_z_i)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural combinational ALU: add-with-carry or AND, zero flag on its output.
    always_comb begin
        logic [64:0] s;
        s         = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {64'b0, alu_c_o};
        alu_out_i = 64'b0;
        alu_c_i   = 1'b0;
        alu_v_i   = 1'b0;
        if (alu_sum_en_o) begin
            alu_out_i = s[63:0];
            alu_c_i   = s[64];
            alu_v_i   = (alu_a_o[63] == alu_b_o[63]) && (s[63] != alu_a_o[63]);
        end else if (alu_and_en_o) begin
            alu_out_i = alu_a_o & alu_b_o;
        end
        alu_z_i = (alu_out_i == 64'b0);
    end

    // Reference: {result, tag, c, v, z, err} expected at writeback for one request.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [TAG_W-1:0] tag);
        logic [64:0] s;
        logic [63:0] alu_res, r;
        logic c, v, e;
        s = 65'b0; alu_res = 64'b0; r = 64'b0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                alu_res = s[63:0]; r = alu_res; c = s[64];
                v = (a[63] == b[63]) && (alu_res[63] != a[63]);
            end
            3'd1, 3'd3, 3'd4: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                alu_res = s[63:0]; c = s[64];
                v = (a[63] != b[63]) && (alu_res[63] != a[63]);
                if (op == 3'd1)      r = alu_res;
                else if (op == 3'd3) r = {63'b0, $signed(a) < $signed(b)};
                else                 r = {63'b0, a < b};
            end
            3'd2: begin
                alu_res = a & b; r = alu_res;
            end
            default: e = 1'b1;
        endcase
        return {r, tag, c, v, (alu_res == 64'b0), e};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // driver: hold request until accepted, push expectation at the accepting edge
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag);
        int waited;
        waited         = 0;
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.tag_i      = tag;
        @(negedge clk_i);
        while (!bus.in_ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        n_cmp++;
        assert (bus.in_ready_o === 1'b1) else begin
            n_bad++;
            $error("FAIL accept_timeout tag=%0d got_ready=%b exp_ready=1", tag, bus.in_ready_o);
        end
        if (bus.in_ready_o) exp_q.push_back(model(op, a, b, tag));
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    // scoreboard: compare every result transfer against the queue head
    always @(negedge clk_i) begin
        if (reset_ni && bus.out_valid_o && bus.out_ready_i) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_result got_tag=%0d got_result=%0h exp=none",
                       bus.tag_o, bus.result_o);
            end
            if (exp_q.size() != 0) begin
                chk("result", {bus.result_o, bus.tag_o, bus.c_o, bus.v_o, bus.z_o, bus.err_o},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_ni        = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_i        = 3'b0;
        bus.a_i         = 64'b0;
        bus.b_i         = 64'b0;
        bus.tag_i       = '0;
        bus.out_ready_i = 1'b1;
        #12;
        chk("rst_in_ready", W'(bus.in_ready_o), W'(1));
        chk("rst_out_valid", W'(bus.out_valid_o), W'(0));
        chk("rst_outputs", {bus.result_o, bus.tag_o, bus.c_o, bus.v_o, bus.z_o, bus.err_o}, W'(0));
        chk("rst_alu_a", W'(alu_a_o), W'(0));
        chk("rst_alu_b", W'(alu_b_o), W'(0));
        chk("rst_alu_ctl", W'({alu_c_o, alu_sum_en_o, alu_and_en_o}), W'(0));
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // latency: valid one edge after accept
        send(3'd0, 64'd5, 64'd7, 5'd3);
        chk("lat_s1_only", W'(bus.out_valid_o), W'(0));
        chk("lat_alu_a", W'(alu_a_o), W'(5));
        @(posedge clk_i);
        #1;
        chk("lat_valid", W'(bus.out_valid_o), W'(1));
        chk("add_5_7", {bus.result_o, bus.tag_o, bus.c_o, bus.v_o, bus.z_o, bus.err_o},
            {64'd12, 5'd3, 4'b0000});

        send(3'd1, 64'd0, 64'd1, 5'd4);
        send(3'd1, 64'd9, 64'd9, 5'd5);
        send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd6);
        send(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7);
        send(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd8);
        send(3'd4, 64'd1, 64'd2, 5'd9);
        send(3'd2, 64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_1111_00FF, 5'd10);
        send(3'd2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 5'd11);
        repeat (3) @(posedge clk_i);
        #1;
        chk("drain_basic", W'(exp_q.size()), W'(0));

        // random ops with random writeback stalls
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(3'($urandom_range(0, 4)), {$urandom, $urandom},
                         {$urandom, $urandom}, TAG_W'(i));
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk_i);
                    #1;
                    bus.out_ready_i = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready_i = 1'b1;
            end
        join
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // back-pressure: four back-to-back ADDs, writeback stalled for 5 cycles
        bus.out_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(3'd0, 64'd100 + 64'(i), 64'd1000 * 64'(i + 1), TAG_W'(i));
                end
            end
            begin
                @(posedge clk_i);
                @(negedge clk_i);
                chk("bp_ready_after_1", W'(bus.in_ready_o), W'(1));
                @(posedge clk_i);
                @(negedge clk_i);
                chk("bp_ready_after_2", W'(bus.in_ready_o), W'(0));
                chk("bp_hold_tag", W'(bus.tag_o), W'(0));
                repeat (3) @(posedge clk_i);
                #1;
                chk("bp_still_held", {bus.result_o, bus.tag_o, bus.out_valid_o}, {64'd1100, 5'd0, 1'b1});
                bus.out_ready_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk_i);
        #1;
        chk("bp_drained", W'(exp_q.size()), W'(0));
        chk("bp_out_idle", W'(bus.out_valid_o), W'(0));

        // reserved opcode
        send(3'b110, 64'd123, 64'd456, 5'd20);
        @(posedge clk_i);
        #1;
        chk("reserved", {bus.result_o, bus.tag_o, bus.err_o}, {64'd0, 5'd20, 1'b1});
        @(posedge clk_i);
        #1;

        // fill both stages, then reset: contents must vanish
        bus.out_ready_i = 1'b0;
        send(3'd0, 64'd1, 64'd1, 5'd21);
        send(3'd0, 64'd2, 64'd2, 5'd22);
        chk("full_ready_low", W'(bus.in_ready_o), W'(0));
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_out_valid", W'(bus.out_valid_o), W'(0));
        chk("mid_rst_in_ready", W'(bus.in_ready_o), W'(1));
        chk("mid_rst_result", {bus.result_o, bus.tag_o}, W'(0));
        exp_q.delete();
        @(negedge clk_i);
        reset_ni        = 1'b1;
        bus.out_ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            chk("post_rst_no_stale", W'(bus.out_valid_o), W'(0));
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_i);
        chk("final_queue_empty", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
